gpu_sm_copyvc: RTL and testbench
================================

// Module: gpu_SM_CopyVC
// PURPOSE
// - VRAM->CPU rectangle copy engine (GP0 C0h); counterpart of the CPU->VRAM copy state machine.
// - Scans rect row-major from (X0,Y0) and issues aligned 32-bit pair reads to the VRAM read port.
// - Extracts in-range pixels, packs them two per 32-bit word and buffers words for GPUREAD pops.
// - Sits between the GPU command decoder (rect regs, activate) and the CPU read interface.
// PARAMETERS
// - FIFO_DEPTH   8  output word FIFO entries (power of 2, >=2); also the in-flight credit limit
// PORTS
// - i_clk              in   1   clock
// - i_rst              in   1   synchronous reset, active high
// - i_activateCopyVC   in   1   start pulse; ignored while o_active=1
// - i_RegX0            in   10  rect origin X (pixels)
// - i_RegY0            in   9   rect origin Y
// - i_RegSizeW         in   11  width, already decoded 1..1024
// - i_RegSizeH         in   10  height, already decoded 1..512
// - o_active           out  1   engine busy (state != VC_WAIT)
// - o_CopyInactiveNextCycle out 1  o_active & next state == VC_WAIT
// - o_readReq          out  1   VRAM pair read request
// - o_readX            out  10  pair address X, bit0 always 0
// - o_readY            out  9   pair address Y
// - i_readAccept       in   1   request taken this cycle when o_readReq=1
// - i_readValid        in   1   read data returned, in request order, >=1 cycle after accept
// - i_readData         in   32  [15:0]=even-X pixel, [31:16]=odd-X pixel
// - o_dataValid        out  1   FIFO not empty (GPUREAD word available)
// - o_data             out  32  FIFO head word
// - i_dataPop          in   1   pop head; ignored when o_dataValid=0
// - i_abort            in   1   only with GPU_COPYVC_ABORT_EN
// BEHAVIOUR
// - Reset: state VC_WAIT; o_readReq=0, o_readX=0, o_readY=0, o_dataValid=0, o_data=0,
//   o_active=0, o_CopyInactiveNextCycle=0; FIFO, packer, credit counter cleared.
// - States: VC_WAIT -(activate)-> VC_START (latch X0,Y0,W,H; line counter=0;
//   pair X=X0&~1) -> VC_READ -(last pair of last line accepted)-> VC_DRAIN
//   -(all returns consumed, final word pushed, FIFO empty)-> VC_WAIT.
// - Per line: pairs from X0&~1 to (X0+W-1)&~1, pair X += 2 modulo 1024;
//   Y = (Y0+line) mod 512. A pair whose X wraps (1022->0) is still issued.
// - Credit: o_readReq=1 in VC_READ only while inflight + fifoCount + packerFull < FIFO_DEPTH;
//   accept increments inflight, i_readValid decrements it; simultaneous = no change.
// - Return path tracks the same pixel window: pixel at x is kept iff it lies in
//   [X0, X0+W-1] mod 1024 for that line; even-X pixel is emitted before odd-X pixel.
// - Packer: pixel stream is continuous across lines; 1st pixel -> [15:0], 2nd -> [31:16],
//   then push word. Push and pop in the same cycle are both honoured.
// - Odd total W*H: last word pushed in VC_DRAIN with [31:16]=16'h0000.
// - A word is never dropped: pushes cannot occur when full (guaranteed by credit).
// - i_readValid in VC_WAIT: ignored. i_activateCopyVC while active: ignored.
// - Reset mid-copy: immediate return to reset values; FIFO contents discarded.
// - Latency: first o_readReq 2 cycles after activate; word visible 1 cycle after
//   the completing i_readValid.
// CONFIGURATION
// - GPU_COPYVC_ABORT_EN defined: i_abort port exists; i_abort=1 in any active state
//   drops o_readReq same cycle, goes to VC_DRAIN; outstanding returns are discarded,
//   FIFO flushed, no pad word; VC_WAIT once inflight=0.
// - Not defined: no i_abort port; copy always runs to completion.
// TESTING
// - X0=0,Y0=0,W=2,H=1, pair {B,A} -> one read (0,0); one word 32'hBBBB_AAAA; idle after pop.
// - X0=1,W=2,H=1, returns {p1,p0},{p3,p2} -> reads X=0,X=2; word {p2,p1}.
// - X0=4,W=3,H=1, returns {p5,p4},{p7,p6} -> words {p5,p4},{16'h0,p6}.
// - X0=1023,Y0=511,W=2,H=2 -> reads (1022,511),(0,511),(1022,0),(0,0); words
//   {p0,p1023} row511, then row0 likewise.
// - FIFO_DEPTH=4, W=16,H=1, no pops -> exactly 4 accepted reads, o_readReq low; each pop
//   releases one read; final 8 words in order, no loss.
// - Abort EN: abort after 2 accepts of W=16 copy -> o_readReq low same cycle; FIFO empty,
//   VC_WAIT after both returns.

Source files
------------

// File: rtl/gpu_sm_copyvc.sv
// VRAM->CPU rectangle copy engine: scans the rect, issues pair reads, packs pixels into a GPUREAD FIFO.
// Optional abort support is enabled with `define GPU_COPYVC_ABORT_EN (adds the i_abort port).
//   state    | meaning
//   VC_WAIT  | idle, waiting for activate
//   VC_START | rect latched, scan pointers initialised
//   VC_READ  | issuing pair reads under credit
//   VC_DRAIN | all reads issued; wait for returns, pad word and empty FIFO
module gpu_sm_copyvc #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_activateCopyVC,
    input  logic [9:0]  i_RegX0,
    input  logic [8:0]  i_RegY0,
    input  logic [10:0] i_RegSizeW,
    input  logic [9:0]  i_RegSizeH,
    output logic        o_active,
    output logic        o_CopyInactiveNextCycle,
    output logic        o_readReq,
    output logic [9:0]  o_readX,
    output logic [8:0]  o_readY,
    input  logic        i_readAccept,
    input  logic        i_readValid,
    input  logic [31:0] i_readData,
    output logic        o_dataValid,
    output logic [31:0] o_data,
`ifdef GPU_COPYVC_ABORT_EN
    input  logic        i_abort,
`endif
    input  logic        i_dataPop
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {VC_WAIT, VC_START, VC_READ, VC_DRAIN} state_t;
    state_t state, state_nx;

    logic [9:0]  x0_r, h_r, line_r, pidx_r, ret_pidx, rd_x;
    logic [8:0]  y0_r, rd_y;
    logic [10:0] w_r;
    logic [CW-1:0] inflight, count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0] mem [FIFO_DEPTH];
    logic [15:0] half_r, half_nx, one_pix;
    logic        half_full, half_full_nx, aborting;
    logic        abort_in, abort_now, flush, accept, ret, pop, push;
    logic [31:0] push_word;
    logic [11:0] span, off_e;
    logic [CW:0] credit_sum;
    logic        pidx_last, line_last, ret_last, keep_even, keep_odd;

`ifdef GPU_COPYVC_ABORT_EN
    assign abort_in = i_abort;
`else
    assign abort_in = 1'b0;
`endif

    // span = pixel offset one past the window, measured from the first (even) pair address
    assign span      = {11'd0, x0_r[0]} + {1'b0, w_r};
    assign pidx_last = ({1'b0, pidx_r, 1'b0} + 12'd2) >= span;
    assign line_last = (line_r == h_r - 10'd1);
    assign off_e     = {1'b0, ret_pidx, 1'b0};
    assign ret_last  = (off_e + 12'd2) >= span;
    assign keep_even = (off_e >= {11'd0, x0_r[0]}) && (off_e < span);
    assign keep_odd  = (off_e + 12'd1) < span;

    assign o_active    = (state != VC_WAIT);
    assign abort_now   = abort_in && o_active;
    assign flush       = abort_now || aborting;
    assign credit_sum  = {1'b0, inflight} + {1'b0, count} + {{CW{1'b0}}, half_full};
    assign o_readReq   = (state == VC_READ) && (credit_sum < DEPTH_C) && !abort_now;
    assign accept      = o_readReq && i_readAccept;
    assign ret         = i_readValid && o_active && (inflight != '0);
    assign o_dataValid = (count != '0);
    assign pop         = i_dataPop && o_dataValid && !flush;
    assign o_data      = o_dataValid ? mem[rd_ptr] : 32'h0;
    assign o_readX     = rd_x;
    assign o_readY     = rd_y;
    assign o_CopyInactiveNextCycle = o_active && (state_nx == VC_WAIT);

    always_comb begin
        state_nx = state;
        case (state)
            VC_WAIT:  if (i_activateCopyVC) state_nx = VC_START;
            VC_START: state_nx = VC_READ;
            VC_READ:  if (accept && pidx_last && line_last) state_nx = VC_DRAIN;
            VC_DRAIN: if (inflight == '0 && (aborting || (!half_full && count == '0)))
                          state_nx = VC_WAIT;
            default:  state_nx = VC_WAIT;
        endcase
        if (abort_now) state_nx = VC_DRAIN;
    end

    // Pixel packer: at most one word is pushed per cycle.
    always_comb begin
        push         = 1'b0;
        push_word    = 32'h0;
        half_nx      = half_r;
        half_full_nx = half_full;
        one_pix      = keep_even ? i_readData[15:0] : i_readData[31:16];
        if (flush) begin
            half_full_nx = 1'b0;
        end else if (ret) begin
            if (keep_even && keep_odd) begin
                push = 1'b1;
                if (half_full) begin
                    push_word = {i_readData[15:0], half_r};
                    half_nx   = i_readData[31:16];
                end else begin
                    push_word = i_readData;
                end
            end else if (keep_even || keep_odd) begin
                if (half_full) begin
                    push         = 1'b1;
                    push_word    = {one_pix, half_r};
                    half_full_nx = 1'b0;
                end else begin
                    half_nx      = one_pix;
                    half_full_nx = 1'b1;
                end
            end
        end else if (state == VC_DRAIN && inflight == '0 && half_full) begin
            push         = 1'b1;
            push_word    = {16'h0000, half_r};
            half_full_nx = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= VC_WAIT;
            x0_r      <= '0;
            y0_r      <= '0;
            w_r       <= '0;
            h_r       <= '0;
            line_r    <= '0;
            pidx_r    <= '0;
            ret_pidx  <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            inflight  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            half_r    <= '0;
            half_full <= 1'b0;
            aborting  <= 1'b0;
        end else begin
            state     <= state_nx;
            half_r    <= half_nx;
            half_full <= half_full_nx;
            if (state == VC_WAIT && i_activateCopyVC) begin
                x0_r <= i_RegX0;
                y0_r <= i_RegY0;
                w_r  <= i_RegSizeW;
                h_r  <= i_RegSizeH;
            end
            if (state == VC_START) begin
                line_r   <= '0;
                pidx_r   <= '0;
                ret_pidx <= '0;
                rd_x     <= {x0_r[9:1], 1'b0};
                rd_y     <= y0_r;
            end
            if (accept) begin
                if (pidx_last) begin
                    pidx_r <= '0;
                    line_r <= line_r + 10'd1;
                    rd_x   <= {x0_r[9:1], 1'b0};
                    rd_y   <= rd_y + 9'd1;
                end else begin
                    pidx_r <= pidx_r + 10'd1;
                    rd_x   <= rd_x + 10'd2;
                end
            end
            if (ret) ret_pidx <= ret_last ? '0 : ret_pidx + 10'd1;
            if (accept && !ret)      inflight <= inflight + 1'b1;
            else if (ret && !accept) inflight <= inflight - 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            if (state_nx == VC_WAIT) aborting <= 1'b0;
            else if (abort_now)      aborting <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !flush) mem[wr_ptr] <= push_word;
    end
endmodule

// File: tb/tb_gpu_sm_copyvc.sv
// Randomized bench for gpu_sm_copyvc: VRAM responder, GPUREAD popper and a pixel-level reference model.
module tb_gpu_sm_copyvc;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, act = 1'b0;
    logic [9:0]  x0 = '0, h = '0;
    logic [8:0]  y0 = '0;
    logic [10:0] w = '0;
    logic        rd_accept = 1'b0, rd_valid = 1'b0, data_pop = 1'b0;
    logic [31:0] rd_data = '0;
    logic        active, cinc, read_req, data_valid;
    logic [9:0]  read_x;
    logic [8:0]  read_y;
    logic [31:0] data;
`ifdef GPU_COPYVC_ABORT_EN
    logic        abort_s = 1'b0;
`endif

    gpu_sm_copyvc #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_activateCopyVC(act),
        .i_RegX0(x0), .i_RegY0(y0), .i_RegSizeW(w), .i_RegSizeH(h),
        .o_active(active), .o_CopyInactiveNextCycle(cinc),
        .o_readReq(read_req), .o_readX(read_x), .o_readY(read_y),
        .i_readAccept(rd_accept), .i_readValid(rd_valid), .i_readData(rd_data),
        .o_dataValid(data_valid), .o_data(data),
`ifdef GPU_COPYVC_ABORT_EN
        .i_abort(abort_s),
`endif
        .i_dataPop(data_pop)
    );

    int total = 0, bad = 0, cyc = 0;
    int acc_pct = 100, pop_pct = 0, ret_pct = 100, ret_delay = 0;
    int n_acc = 0, n_pop = 0;
    int unsigned salt = 0;
    bit start_req = 0, noise_en = 0, lat_chk = 0;
    bit prev_active = 0, prev_cinc = 0, prev_rv = 0;
    logic [18:0] exp_reads[$];
    logic [31:0] exp_words[$];
    logic [31:0] ret_q[$];
    logic [31:0] lit_q[$];
    int          ret_due[$];

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pix(int x, int y);
        int unsigned v;
        v = $unsigned(x) * 32'd40503 + $unsigned(y) * 32'd9973 + salt;
        return v[23:8] ^ v[15:0];
    endfunction

    // Expected pair reads and packed words, derived directly from the rect rules.
    task automatic model_copy(int xs, int ys, int ws, int hs);
        logic [15:0] px[$];
        logic [15:0] a, b;
        int np, yl, xb;
        np = ((xs % 2) + ws + 1) / 2;
        xb = xs - (xs % 2);
        for (int l = 0; l < hs; l++) begin
            yl = (ys + l) % 512;
            for (int k = 0; k < np; k++) exp_reads.push_back({10'((xb + 2 * k) % 1024), 9'(yl)});
            for (int i = 0; i < ws; i++) px.push_back(pix((xs + i) % 1024, yl));
        end
        while (px.size() >= 2) begin
            a = px.pop_front();
            b = px.pop_front();
            exp_words.push_back({b, a});
        end
        if (px.size() == 1) exp_words.push_back({16'h0000, px.pop_front()});
    endtask

    // One clock: drive VRAM/pop/activate inputs, score transactions, advance past the edge.
    task automatic step();
        logic [31:0] d;
        act = start_req | (noise_en & active & ($urandom_range(15) == 0));
        rd_valid = 1'b0;
        rd_data  = $urandom;
        if (ret_q.size() > 0 && ret_due[0] <= cyc + 1 && $urandom_range(99) < ret_pct) begin
            rd_valid = 1'b1;
            rd_data  = ret_q.pop_front();
            void'(ret_due.pop_front());
        end
        rd_accept = ($urandom_range(99) < acc_pct);
        if (read_req && rd_accept) begin
            n_acc++;
            check("read_x_even", 64'(read_x[0]), 64'd0);
            if (exp_reads.size() == 0) begin
                total++; bad++;
                $display("FAIL read_extra: got %0h,%0h expected no read", read_x, read_y);
            end else check("read_addr", {read_x, read_y}, exp_reads.pop_front());
            if (lit_q.size() > 0) d = lit_q.pop_front();
            else d = {pix(int'(read_x) + 1, int'(read_y)), pix(int'(read_x), int'(read_y))};
            ret_q.push_back(d);
            ret_due.push_back(cyc + 2 + int'($urandom_range(0, ret_delay)));
        end
        data_pop = ($urandom_range(99) < pop_pct);
        if (data_valid && data_pop) begin
            n_pop++;
            if (exp_words.size() == 0) begin
                total++; bad++;
                $display("FAIL word_extra: got %0h expected no word", data);
            end else check("word", data, exp_words.pop_front());
        end
        if (!data_valid) check("data_zero_when_empty", data, 0);
        prev_active = active;
        prev_cinc   = cinc;
        prev_rv     = rd_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_cinc) check("inactive_after_cinc", 64'(active), 64'd0);
        if (prev_active && !active) check("cinc_before_idle", 64'(prev_cinc), 64'd1);
        if (lat_chk && prev_rv) check("word_latency", 64'(data_valid), 64'd1);
    endtask

    task automatic start_copy(int xs, int ys, int ws, int hs);
        x0 = 10'(xs); y0 = 9'(ys); w = 11'(ws); h = 10'(hs);
        start_req = 1'b1;
        step();
        start_req = 1'b0;
    endtask

    task automatic wait_idle(int max);
        int n = 0;
        while (active && n < max) begin
            step();
            n++;
        end
        check("idle_reached", 64'(active), 64'd0);
        check("reads_left", 64'(exp_reads.size()), 64'd0);
        check("words_left", 64'(exp_words.size()), 64'd0);
        check("valid_when_idle", 64'(data_valid), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_active", 64'(active), 0);
        check("rst_cinc", 64'(cinc), 0);
        check("rst_req", 64'(read_req), 0);
        check("rst_x", 64'(read_x), 0);
        check("rst_y", 64'(read_y), 0);
        check("rst_valid", 64'(data_valid), 0);
        check("rst_data", data, 0);
        rst = 1'b0;
        step();

        // 2x1 at origin: single pair, literal word, latency checks
        exp_reads.push_back({10'd0, 9'd0});
        exp_words.push_back(32'hBBBB_AAAA);
        lit_q.push_back(32'hBBBB_AAAA);
        acc_pct = 0; pop_pct = 0; ret_delay = 0; lat_chk = 1;
        start_copy(0, 0, 2, 1);
        check("t1_active", 64'(active), 1);
        check("t1_no_req_yet", 64'(read_req), 0);
        step();
        check("t1_req_2cyc", 64'(read_req), 1);
        acc_pct = 100;
        repeat (3) step();
        check("t1_word_head", data, 32'hBBBB_AAAA);
        lat_chk = 0;
        pop_pct = 100;
        wait_idle(50);

        rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        check("wait_ignores_valid", 64'(data_valid), 0);

        // odd origin, 2 wide
        exp_reads.push_back({10'd0, 9'd5});
        exp_reads.push_back({10'd2, 9'd5});
        lit_q.push_back(32'h1111_0000);
        lit_q.push_back(32'h3333_2222);
        exp_words.push_back(32'h2222_1111);
        pop_pct = 50; ret_delay = 2;
        start_copy(1, 5, 2, 1);
        wait_idle(100);

        // 3 wide: pad word
        exp_reads.push_back({10'd4, 9'd9});
        exp_reads.push_back({10'd6, 9'd9});
        lit_q.push_back(32'h5555_4444);
        lit_q.push_back(32'h7777_6666);
        exp_words.push_back(32'h5555_4444);
        exp_words.push_back(32'h0000_6666);
        start_copy(4, 9, 3, 1);
        wait_idle(100);

        // X and Y wrap
        exp_reads.push_back({10'd1022, 9'd511});
        exp_reads.push_back({10'd0, 9'd511});
        exp_reads.push_back({10'd1022, 9'd0});
        exp_reads.push_back({10'd0, 9'd0});
        lit_q.push_back(32'hA3FF_A3FE);
        lit_q.push_back(32'hA001_A000);
        lit_q.push_back(32'hB3FF_B3FE);
        lit_q.push_back(32'hB001_B000);
        exp_words.push_back(32'hA000_A3FF);
        exp_words.push_back(32'hB000_B3FF);
        start_copy(1023, 511, 2, 2);
        wait_idle(100);

        // credit limit with no pops
        salt = 32'h1234_5678;
        model_copy(0, 3, 16, 1);
        n_acc = 0; n_pop = 0; acc_pct = 100; pop_pct = 0; ret_delay = 0;
        start_copy(0, 3, 16, 1);
        repeat (30) step();
        check("bp_accepts", 64'(n_acc), 4);
        check("bp_req_low", 64'(read_req), 0);
        check("bp_valid", 64'(data_valid), 1);
        for (int i = 0; i < 2; i++) begin
            pop_pct = 100;
            step();
            pop_pct = 0;
            repeat (8) step();
            check("bp_release", 64'(n_acc), 64'(5 + i));
        end
        pop_pct = 100;
        wait_idle(200);
        check("bp_words", 64'(n_pop), 8);

        // reset in the middle of a copy
        salt = $urandom;
        model_copy(10, 20, 30, 2);
        pop_pct = 30;
        start_copy(10, 20, 30, 2);
        repeat (6) step();
        rst = 1'b1; rd_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_active", 64'(active), 0);
        check("mid_rst_req", 64'(read_req), 0);
        check("mid_rst_valid", 64'(data_valid), 0);
        check("mid_rst_x", 64'(read_x), 0);
        exp_reads.delete(); exp_words.delete(); ret_q.delete(); ret_due.delete();
        rst = 1'b0;
        step();

        // full-width line wrapping through X=0
        salt = $urandom;
        model_copy(6, 100, 1024, 1);
        acc_pct = 90; pop_pct = 90; ret_pct = 90; ret_delay = 3;
        start_copy(6, 100, 1024, 1);
        wait_idle(8000);

        for (int t = 0; t < 25; t++) begin
            int xs, ys, ws, hs;
            xs = ($urandom_range(3) == 0) ? 1024 - int'($urandom_range(1, 4)) : int'($urandom_range(1023));
            ys = ($urandom_range(3) == 0) ? 511 - int'($urandom_range(0, 2)) : int'($urandom_range(511));
            ws = int'($urandom_range(1, 40));
            hs = int'($urandom_range(1, 3));
            salt = $urandom;
            acc_pct = int'($urandom_range(30, 100));
            pop_pct = int'($urandom_range(20, 100));
            ret_pct = int'($urandom_range(30, 100));
            ret_delay = int'($urandom_range(0, 4));
            model_copy(xs, ys, ws, hs);
            start_copy(xs, ys, ws, hs);
            noise_en = 1;
            wait_idle(6000);
            noise_en = 0;
        end

`ifdef GPU_COPYVC_ABORT_EN
        begin
            int g = 0;
            salt = $urandom;
            model_copy(0, 7, 16, 1);
            n_acc = 0; acc_pct = 100; pop_pct = 0; ret_pct = 100; ret_delay = 4;
            start_copy(0, 7, 16, 1);
            while (n_acc < 2 && g < 20) begin
                step();
                g++;
            end
            acc_pct = 0;
            abort_s = 1'b1;
            #1;
            check("abort_req_drop", 64'(read_req), 0);
            step();
            abort_s = 1'b0;
            exp_reads.delete(); exp_words.delete();
            check("abort_flushed", 64'(data_valid), 0);
            g = 0;
            while (active && g < 50) begin
                step();
                check("abort_fifo_empty", 64'(data_valid), 0);
                g++;
            end
            check("abort_idle", 64'(active), 0);
            check("abort_accepts", 64'(n_acc), 2);
            check("abort_returns_done", 64'(ret_q.size()), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
